tt_um_divider4: RTL and testbench



---
 rtl/tt_um_divider4.sv | 130 +++++++++++++
 tb/tb_tt_um_divider4.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/tt_um_divider4.sv
// Sequential restoring shift-subtract divider on the TinyTapeout user-tile pinout: one quotient bit per clock.
// Optional two's-complement mode is enabled by defining DIVIDER_SIGNED_EN.
`timescale 1ns/1ps
module tt_um_divider4 #(
    parameter int WIDTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Visible to checkers bound by hierarchy.
    state_t state, state_nxt;

    logic [WIDTH-1:0] a_in, b_in, a_mag_in, b_mag_in;
    logic             start, accept;
    logic [WIDTH-1:0] qsh, b_mag, q_reg, r_reg;
    logic [WIDTH:0]   rem, t, rem_nxt;
    logic [CW-1:0]    cnt;
    logic             ge, busy, done, div0, ovf;
    logic [WIDTH-1:0] q_mag, q_fin, r_fin;
    logic             ovf_fin;
    logic             unused_in;

    assign a_in      = ui_in[3:0];
    assign b_in      = ui_in[7:4];
    assign start     = uio_in[0];
    assign accept    = start && (state != RUN);
    assign unused_in = &{1'b0, ena, uio_in[7:1]};

`ifdef DIVIDER_SIGNED_EN
    logic a_neg, b_neg;
    assign a_mag_in = a_in[WIDTH-1] ? (~a_in + 1'b1) : a_in;
    assign b_mag_in = b_in[WIDTH-1] ? (~b_in + 1'b1) : b_in;
`else
    assign a_mag_in = a_in;
    assign b_mag_in = b_in;
`endif

    // Datapath for one restoring step.
    always_comb begin
        t       = {rem[WIDTH-1:0], qsh[WIDTH-1]};
        ge      = (t >= {1'b0, b_mag});
        rem_nxt = ge ? (t - {1'b0, b_mag}) : t;
        q_mag   = {qsh[WIDTH-2:0], ge};
`ifdef DIVIDER_SIGNED_EN
        // Truncate toward zero; remainder follows the dividend's sign.
        q_fin   = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
        r_fin   = a_neg ? (~rem_nxt[WIDTH-1:0] + 1'b1) : rem_nxt[WIDTH-1:0];
        ovf_fin = (q_mag == {1'b1, {(WIDTH-1){1'b0}}}) && !(a_neg ^ b_neg);
`else
        q_fin   = q_mag;
        r_fin   = rem_nxt[WIDTH-1:0];
        ovf_fin = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = (b_in == '0) ? DONE : RUN;
            RUN:        if (cnt == '0) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qsh   <= '0;
            rem   <= '0;
            b_mag <= '0;
            cnt   <= '0;
            q_reg <= '0;
            r_reg <= '0;
            div0  <= 1'b0;
            ovf   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            a_neg <= 1'b0;
            b_neg <= 1'b0;
`endif
        end else if (accept) begin
            div0 <= (b_in == '0);
            ovf  <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            a_neg <= a_in[WIDTH-1];
            b_neg <= b_in[WIDTH-1];
`endif
            if (b_in == '0) begin
                q_reg <= '1;
                r_reg <= a_in;
            end else begin
                qsh   <= a_mag_in;
                b_mag <= b_mag_in;
                rem   <= '0;
                cnt   <= CW'(WIDTH - 1);
            end
        end else if (state == RUN) begin
            qsh <= q_mag;
            rem <= rem_nxt;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
                q_reg <= q_fin;
                r_reg <= r_fin;
                ovf   <= ovf_fin;
            end
        end
    end

    assign uo_out  = {r_reg, q_reg};
    assign uio_out = {3'b000, ovf, div0, done, busy, 1'b0};
    assign uio_oe  = 8'b0001_1110;
endmodule

// File: tb/tb_tt_um_divider4.sv
// Directed bench for tt_um_divider4: latency, divide-by-zero, ignored start, mid-run reset, full unsigned sweep.
`timescale 1ns/1ps
module tb_tt_um_divider4;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    tt_um_divider4 dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] F_BUSY = 8'h02, F_DONE = 8'h04, F_DIV0 = 8'h08, F_OVF = 8'h10;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives a one-cycle start pulse; returns at the falling edge after the sampling edge.
    task automatic start_op(input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        ui_in  = {b, a};
        uio_in = 8'h01;
        @(posedge clk);
        @(negedge clk);
        uio_in = 8'h00;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [3:0] q, r;
        // Reset
        #12;
        chk("reset_uo", uo_out, 8'h00);
        chk("reset_uio", uio_out, 8'h00);
        chk("uio_oe", uio_oe, 8'h1E);
        @(negedge clk);
        rst_n = 1'b1;

        // 13/3: busy from edge k through k+3, result at k+4
        start_op(4'd13, 4'd3);
        chk("13/3_busy_k", uio_out, F_BUSY);
        chk("13/3_hold_k", uo_out, 8'h00);
        wait_edges(3);
        chk("13/3_busy_k3", uio_out, F_BUSY);
        chk("13/3_hold_k3", uo_out, 8'h00);
        wait_edges(1);
        chk("13/3_result", uo_out, 8'h14);
        chk("13/3_flags", uio_out, F_DONE);

        // Divide by zero completes one cycle after start
        start_op(4'd7, 4'd0);
        chk("7/0_result", uo_out, 8'h7F);
        chk("7/0_flags", uio_out, F_DONE | F_DIV0);

        start_op(4'd15, 4'd1);
        wait_edges(4);
        chk("15/1_result", uo_out, 8'h0F);
        chk("15/1_flags", uio_out, F_DONE);

        start_op(4'd2, 4'd9);
        wait_edges(4);
        chk("2/9_result", uo_out, 8'h20);

        // Start during RUN is ignored and operands stay latched
        start_op(4'd9, 4'd2);
        wait_edges(2);
        ui_in  = {4'd5, 4'd5};
        uio_in = 8'h01;
        @(posedge clk);
        @(negedge clk);
        uio_in = 8'h00;
        chk("ign_busy", uio_out, F_BUSY);
        wait_edges(1);
        chk("ign_result", uo_out, 8'h14);
        chk("ign_flags", uio_out, F_DONE);
        start_op(4'd5, 4'd5);
        chk("restart_busy", uio_out, F_BUSY);
        chk("restart_hold", uo_out, 8'h14);
        wait_edges(4);
        chk("5/5_result", uo_out, 8'h01);

        // Asynchronous reset in the second RUN cycle
        start_op(4'd6, 4'd4);
        wait_edges(1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_uo", uo_out, 8'h00);
        chk("midrst_uio", uio_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        wait_edges(2);
        chk("post_rst_idle", uio_out, 8'h00);
        start_op(4'd6, 4'd4);
        wait_edges(4);
        chk("6/4_result", uo_out, 8'h21);
        chk("6/4_flags", uio_out, F_DONE);

`ifdef DIVIDER_SIGNED_EN
        start_op(4'h9, 4'h2);
        wait_edges(4);
        chk("s_-7/2_result", uo_out, 8'hFD);
        chk("s_-7/2_flags", uio_out, F_DONE);
        start_op(4'h8, 4'hF);
        wait_edges(4);
        chk("s_-8/-1_result", uo_out, 8'h08);
        chk("s_-8/-1_flags", uio_out, F_DONE | F_OVF);
        start_op(4'h6, 4'hC);
        wait_edges(4);
        chk("s_6/-4_result", uo_out, 8'h2F);
        chk("s_6/-4_flags", uio_out, F_DONE);
        start_op(4'h9, 4'h0);
        chk("s_div0_result", uo_out, 8'h9F);
        chk("s_div0_flags", uio_out, F_DONE | F_DIV0);
`else
        // Exhaustive unsigned sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                start_op(4'(a), 4'(b));
                if (b == 0) begin
                    chk("sweep_div0", uo_out, {4'(a), 4'hF});
                    chk("sweep_div0_flags", uio_out, F_DONE | F_DIV0);
                end else begin
                    wait_edges(4);
                    q = 4'(a / b);
                    r = 4'(a % b);
                    chk("sweep_qr", uo_out, {r, q});
                    chk("sweep_flags", uio_out, F_DONE);
                    chk("sweep_identity", 8'(int'(uo_out[3:0]) * b + int'(uo_out[7:4])), 8'(a));
                    chk("sweep_r_lt_b", {7'd0, (int'(uo_out[7:4]) < b)}, 8'h01);
                end
            end
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
